spi_tx_engine: RTL and testbench

- Full-duplex SPI mode-0 master shift engine. It sits directly downstream of the slow-clock generator.
- It consumes the generator's square-wave output as its bit-rate source and produces serial clock, chip-select and MOSI.
- It samples MISO and returns the received word through a valid/ready load interface plus a done strobe.
- Everything runs on the system clock; the bit-rate input is synchronous to clk, so no CDC synchroniser is needed.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_tx_engine_edge_detect.sv | 21 ++
 rtl/spi_tx_engine.sv | 111 +++++++++++
 tb/tb_spi_tx_engine.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI mode-0 master shift engine.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT
  } spi_state_t;

  localparam int unsigned SPI_MIN_WIDTH = 2;

  // Counter must represent WIDTH itself, since the final fall is taken at bit_cnt == WIDTH.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/spi_tx_engine_edge_detect.sv
// Rise/fall detector for a signal already synchronous to clk.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev;

  // History tracks sig unconditionally so re-enabling downstream never sees a stale edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= sig;
  end

  assign rise = sig & ~prev;
  assign fall = ~sig & prev;

endmodule

// File: rtl/spi_tx_engine.sv
// Full-duplex SPI mode-0 master; bit timing comes from the sck_src square wave.
module spi_tx_engine #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sck_src,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             done,
  output logic             sck,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  import spi_pkg::*;

  localparam int unsigned CW = cnt_width(WIDTH);

  spi_state_t       state;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [CW-1:0]    bit_cnt;
  logic             src_rise;
  logic             src_fall;
  logic             rise_en;
  logic             fall_en;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] tx_shifted;
  logic [WIDTH-1:0] rx_shifted;

  edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (sck_src),
    .rise  (src_rise),
    .fall  (src_fall)
  );

  assign rise_en  = en & src_rise;
  assign fall_en  = en & src_fall;
  assign tx_ready = (state == IDLE);

  assign first_bit  = MSB_FIRST ? tx_data[WIDTH-1] : tx_data[0];
  assign next_bit   = MSB_FIRST ? tx_sr[WIDTH-2]   : tx_sr[1];
  assign tx_shifted = MSB_FIRST ? {tx_sr[WIDTH-2:0], 1'b0} : {1'b0, tx_sr[WIDTH-1:1]};
  assign rx_shifted = MSB_FIRST ? {rx_sr[WIDTH-2:0], miso} : {miso, rx_sr[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
      done    <= 1'b0;
      sck     <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            tx_sr   <= tx_data;
            rx_sr   <= '0;
            bit_cnt <= '0;
            cs_n    <= 1'b0;
            mosi    <= first_bit;
            state   <= LEAD;
          end
        end

        LEAD: begin
          if (fall_en) state <= SHIFT;
        end

        SHIFT: begin
          // sck follows sck_src one clk late; entry and exit both happen on a fall, so no runt pulse.
          if (en) sck <= sck_src;
          if (rise_en) begin
            rx_sr   <= rx_shifted;
            bit_cnt <= bit_cnt + CW'(1);
          end
          if (fall_en) begin
            if (bit_cnt == CW'(WIDTH)) begin
              state   <= IDLE;
              cs_n    <= 1'b1;
              sck     <= 1'b0;
              mosi    <= 1'b0;
              rx_data <= rx_sr;
              done    <= 1'b1;
            end else begin
              tx_sr <= tx_shifted;
              mosi  <= next_bit;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_engine.sv
// Directed bench: MSB-first loopback instance (a) and LSB-first miso-high instance (b).
module tb_spi_tx_engine;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       sck_src  = 1'b0;

  logic       en_a       = 1'b1;
  logic [7:0] tx_data_a  = '0;
  logic       tx_valid_a = 1'b0;
  logic       tx_ready_a;
  logic [7:0] rx_data_a;
  logic       done_a, sck_a, cs_n_a, mosi_a, miso_a;

  logic       en_b       = 1'b1;
  logic [7:0] tx_data_b  = '0;
  logic       tx_valid_b = 1'b0;
  logic       tx_ready_b;
  logic [7:0] rx_data_b;
  logic       done_b, sck_b, cs_n_b, mosi_b, miso_b;

  int checks = 0;
  int errors = 0;

  assign miso_a = mosi_a;
  assign miso_b = 1'b1;

  spi_tx_engine #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .sck_src(sck_src),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .done(done_a), .sck(sck_a), .cs_n(cs_n_a),
    .mosi(mosi_a), .miso(miso_a)
  );

  spi_tx_engine #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .sck_src(sck_src),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .done(done_b), .sck(sck_b), .cs_n(cs_n_b),
    .mosi(mosi_b), .miso(miso_b)
  );

  always #5 clk = ~clk;

  // sck_src period = 4 clk, changing on negedge like a registered divider output
  initial begin : src_gen
    logic ph;
    ph = 1'b0;
    forever begin
      @(negedge clk);
      if (ph) sck_src = ~sck_src;
      ph = ~ph;
    end
  end

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (cs_n_a !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b expected 1", cs_n_a); end
    checks++; if (sck_a !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b expected 0", sck_a); end
    checks++; if (mosi_a !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b expected 0", mosi_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done_a); end
    checks++; if (rx_data_a !== 8'h00) begin errors++; $display("FAIL rst_rx: got %h expected 00", rx_data_a); end
    checks++; if (tx_ready_a !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", tx_ready_a); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [7:0] mword;
    logic       last_sck, cs_acc, cs_done, seen;
    int         rises, dones, after;
    @(negedge clk);
    tx_data_a = 8'hA5; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    cs_acc = cs_n_a;
    checks++; if (cs_acc !== 1'b0) begin errors++; $display("FAIL t1_cs_accept: got %b expected 0", cs_acc); end
    checks++; if (tx_ready_a !== 1'b0) begin errors++; $display("FAIL t1_ready_busy: got %b expected 0", tx_ready_a); end
    mword = '0; rises = 0; dones = 0; after = 0; seen = 1'b0; cs_done = 1'b0; last_sck = sck_a;
    for (int c = 0; c < 200 && after < 8; c++) begin
      @(negedge clk);
      if (sck_a && !last_sck) begin rises++; mword = {mword[6:0], mosi_a}; end
      last_sck = sck_a;
      if (done_a) begin dones++; cs_done = cs_n_a; seen = 1'b1; end
      if (seen) after++;
    end
    checks++; if (!seen) begin errors++; $display("FAIL t1_timeout: got no done expected done within 200 clk"); end
    checks++; if (mword !== 8'hA5) begin errors++; $display("FAIL t1_mosi_seq: got %h expected a5", mword); end
    checks++; if (rises !== 8) begin errors++; $display("FAIL t1_sck_rises: got %0d expected 8", rises); end
    checks++; if (rx_data_a !== 8'hA5) begin errors++; $display("FAIL t1_rx: got %h expected a5", rx_data_a); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL t1_done_count: got %0d expected 1", dones); end
    checks++; if (cs_done !== 1'b1) begin errors++; $display("FAIL t1_cs_at_done: got %b expected 1", cs_done); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] mword;
    logic       last_sck, first, seen;
    int         rises, dones, after;
    @(negedge clk);
    tx_data_b = 8'h01; tx_valid_b = 1'b1;
    @(negedge clk);
    tx_valid_b = 1'b0;
    mword = '0; rises = 0; dones = 0; after = 0; seen = 1'b0; first = 1'bx; last_sck = sck_b;
    for (int c = 0; c < 200 && after < 8; c++) begin
      @(negedge clk);
      if (sck_b && !last_sck) begin
        if (rises == 0) first = mosi_b;
        rises++;
        mword = {mosi_b, mword[7:1]};
      end
      last_sck = sck_b;
      if (done_b) begin dones++; seen = 1'b1; end
      if (seen) after++;
    end
    checks++; if (first !== 1'b1) begin errors++; $display("FAIL t2_first_bit: got %b expected 1", first); end
    checks++; if (mword !== 8'h01) begin errors++; $display("FAIL t2_mosi_seq: got %h expected 01", mword); end
    checks++; if (rx_data_b !== 8'hFF) begin errors++; $display("FAIL t2_rx: got %h expected ff", rx_data_b); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL t2_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_reset_mid();
    logic last_sck, seen;
    int   rises, dones, after;
    @(negedge clk);
    tx_data_a = 8'hFF; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    rises = 0; last_sck = sck_a;
    for (int c = 0; c < 100 && rises < 3; c++) begin
      @(negedge clk);
      if (sck_a && !last_sck) rises++;
      last_sck = sck_a;
    end
    checks++; if (rises !== 3) begin errors++; $display("FAIL t3_pre_rises: got %0d expected 3", rises); end
    #2 reset = 1'b1;
    #1;
    checks++; if (cs_n_a !== 1'b1) begin errors++; $display("FAIL t3_async_cs_n: got %b expected 1", cs_n_a); end
    checks++; if (sck_a !== 1'b0) begin errors++; $display("FAIL t3_async_sck: got %b expected 0", sck_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL t3_async_done: got %b expected 0", done_a); end
    checks++; if (rx_data_a !== 8'h00) begin errors++; $display("FAIL t3_async_rx: got %h expected 00", rx_data_a); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (tx_ready_a !== 1'b1) begin errors++; $display("FAIL t3_ready_after: got %b expected 1", tx_ready_a); end
    tx_data_a = 8'h3C; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    dones = 0; after = 0; seen = 1'b0;
    for (int c = 0; c < 200 && after < 8; c++) begin
      @(negedge clk);
      if (done_a) begin dones++; seen = 1'b1; end
      if (seen) after++;
    end
    checks++; if (rx_data_a !== 8'h3C) begin errors++; $display("FAIL t3_rx: got %h expected 3c", rx_data_a); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL t3_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx1, rx2;
    logic       cs_done, rdy_done, cs_after, pend;
    int         dones;
    @(negedge clk);
    tx_data_a = 8'h11; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_data_a = 8'h22;
    dones = 0; pend = 1'b0; rx1 = 'x; rx2 = 'x; cs_done = 1'b0; rdy_done = 1'b0; cs_after = 1'b1;
    for (int c = 0; c < 400 && dones < 2; c++) begin
      @(negedge clk);
      if (pend) begin cs_after = cs_n_a; tx_valid_a = 1'b0; pend = 1'b0; end
      if (done_a) begin
        dones++;
        if (dones == 1) begin rx1 = rx_data_a; cs_done = cs_n_a; rdy_done = tx_ready_a; pend = 1'b1; end
        else rx2 = rx_data_a;
      end
    end
    tx_valid_a = 1'b0;
    checks++; if (dones !== 2) begin errors++; $display("FAIL t4_done_count: got %0d expected 2", dones); end
    checks++; if (rx1 !== 8'h11) begin errors++; $display("FAIL t4_rx1: got %h expected 11", rx1); end
    checks++; if (rx2 !== 8'h22) begin errors++; $display("FAIL t4_rx2: got %h expected 22", rx2); end
    checks++; if (rdy_done !== 1'b1) begin errors++; $display("FAIL t4_ready_in_done: got %b expected 1", rdy_done); end
    checks++; if ({cs_done, cs_after} !== 2'b10) begin errors++; $display("FAIL t4_cs_gap: got %b expected 10", {cs_done, cs_after}); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_enable_freeze();
    logic       last_sck, s0, m0, seen;
    logic [7:0] mword;
    int         rises, dones, after, frz_bad;
    @(negedge clk);
    tx_data_a = 8'h5A; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    rises = 0; mword = '0; last_sck = sck_a;
    for (int c = 0; c < 100 && rises < 3; c++) begin
      @(negedge clk);
      if (sck_a && !last_sck) begin rises++; mword = {mword[6:0], mosi_a}; end
      last_sck = sck_a;
    end
    en_a = 1'b0;
    s0 = sck_a; m0 = mosi_a; frz_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (sck_a !== s0 || mosi_a !== m0 || cs_n_a !== 1'b0 || done_a !== 1'b0) frz_bad++;
    end
    en_a = 1'b1;
    checks++; if (frz_bad !== 0) begin errors++; $display("FAIL t5_frozen: got %0d changed cycles expected 0", frz_bad); end
    dones = 0; after = 0; seen = 1'b0;
    for (int c = 0; c < 200 && after < 8; c++) begin
      @(negedge clk);
      if (sck_a && !last_sck) begin rises++; mword = {mword[6:0], mosi_a}; end
      last_sck = sck_a;
      if (done_a) begin dones++; seen = 1'b1; end
      if (seen) after++;
    end
    checks++; if (rises !== 8) begin errors++; $display("FAIL t5_sck_rises: got %0d expected 8", rises); end
    checks++; if (mword !== 8'h5A) begin errors++; $display("FAIL t5_mosi_seq: got %h expected 5a", mword); end
    checks++; if (rx_data_a !== 8'h5A) begin errors++; $display("FAIL t5_rx: got %h expected 5a", rx_data_a); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL t5_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_busy_valid();
    logic seen, rdy_busy;
    int   dones, cs_low_after;
    @(negedge clk);
    tx_data_a = 8'hC3; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    repeat (10) @(negedge clk);
    rdy_busy = tx_ready_a;
    tx_data_a = 8'h77; tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    checks++; if (rdy_busy !== 1'b0) begin errors++; $display("FAIL t6_ready_busy: got %b expected 0", rdy_busy); end
    dones = 0; seen = 1'b0; cs_low_after = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (seen && cs_n_a === 1'b0) cs_low_after++;
      if (done_a) begin dones++; seen = 1'b1; end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL t6_done_count: got %0d expected 1", dones); end
    checks++; if (rx_data_a !== 8'hC3) begin errors++; $display("FAIL t6_rx: got %h expected c3", rx_data_a); end
    checks++; if (cs_low_after !== 0) begin errors++; $display("FAIL t6_extra_xfer: got %0d cs_n low cycles expected 0", cs_low_after); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_lsb_first();
    test_reset_mid();
    test_back_to_back();
    test_enable_freeze();
    test_busy_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
